// File: rtl/scan_seq_pkg.sv
// Shared types and sizing helpers for the scan-test sequencer.
// Holds the FSM state encoding, the default chain length and the counter-width function.
package scan_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    FINISH  = 2'd3
  } state_t;

  localparam int DEF_CHAIN_LEN = 32;

  // Bits needed to hold a count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_seq_ctrl.sv
// Scan-test session sequencer: streams stimulus bits into a scan chain, pulses
// capture, and streams response bits out while the next pattern loads.
module scan_seq_ctrl
  import scan_seq_pkg::*;
#(
  parameter int CHAIN_LEN = DEF_CHAIN_LEN,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [CNT_W-1:0] PAT_CNT,
  input  logic             PI_VALID,
  input  logic             PI_DATA,
  output logic             PI_READY,
  output logic             SO_VALID,
  output logic             SO_DATA,
  input  logic             SO_READY,
  output logic             SE,
  output logic             SI,
  input  logic             SO,
  output logic             SCLK_EN,
  output logic             BUSY,
  output logic             DONE
);

  localparam int             SCW       = cnt_width(CHAIN_LEN);
  localparam logic [SCW-1:0] LAST_BEAT = SCW'(CHAIN_LEN - 1);

  state_t           state_q, state_d;
  logic [SCW-1:0]   shift_cnt_q, shift_cnt_d;
  logic [CNT_W-1:0] pat_rem_q, pat_rem_d;
  logic             load_q, load_d;
  logic             unload_q, unload_d;
  logic             beat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      shift_cnt_q <= '0;
      pat_rem_q   <= '0;
      load_q      <= 1'b0;
      unload_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_rem_q   <= pat_rem_d;
      load_q      <= load_d;
      unload_q    <= unload_d;
    end
  end

  // Outputs are decoded from the current state plus the live handshake inputs,
  // so a stall freezes every register simply by producing no beat.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pat_rem_d   = pat_rem_q;
    load_d      = load_q;
    unload_d    = unload_q;
    beat        = 1'b0;
    PI_READY    = 1'b0;
    SO_VALID    = 1'b0;
    SO_DATA     = 1'b0;
    SE          = 1'b0;
    SI          = 1'b0;
    SCLK_EN     = 1'b0;
    BUSY        = 1'b0;
    DONE        = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          if (PAT_CNT != '0) begin
            pat_rem_d   = PAT_CNT;
            load_d      = 1'b1;
            unload_d    = 1'b0;
            shift_cnt_d = '0;
            state_d     = SHIFT;
          end else begin
            state_d = FINISH;
          end
        end
      end

      SHIFT: begin
        BUSY     = 1'b1;
        SE       = 1'b1;
        beat     = (!load_q || PI_VALID) && (!unload_q || SO_READY);
        SCLK_EN  = beat;
        PI_READY = load_q && (!unload_q || SO_READY);
        SO_VALID = unload_q && (!load_q || PI_VALID);
        SO_DATA  = SO;
        SI       = load_q && PI_DATA;
        if (beat) begin
          if (shift_cnt_q == LAST_BEAT) begin
            shift_cnt_d = '0;
            state_d     = load_q ? CAPTURE : FINISH;
          end else begin
            shift_cnt_d = shift_cnt_q + SCW'(1);
          end
        end
      end

      // The pattern just loaded is consumed here, so another load follows only
      // if more than one pattern was outstanding on entry.
      CAPTURE: begin
        BUSY      = 1'b1;
        SCLK_EN   = 1'b1;
        pat_rem_d = pat_rem_q - CNT_W'(1);
        unload_d  = 1'b1;
        load_d    = (pat_rem_q > CNT_W'(1));
        state_d   = SHIFT;
      end

      FINISH: begin
        BUSY     = 1'b1;
        DONE     = 1'b1;
        load_d   = 1'b0;
        unload_d = 1'b0;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_seq_ctrl.sv
// Directed, table-driven bench for scan_seq_ctrl with a 4-flop chain.
// Per-cycle vectors cover full sessions; hand sequences cover reset and session-level corners.
module tb_scan_seq_ctrl;

  logic       CLK;
  logic       RST;
  logic       START;
  logic [7:0] PAT_CNT;
  logic       PI_VALID;
  logic       PI_DATA;
  logic       PI_READY;
  logic       SO_VALID;
  logic       SO_DATA;
  logic       SO_READY;
  logic       SE;
  logic       SI;
  logic       SO;
  logic       SCLK_EN;
  logic       BUSY;
  logic       DONE;

  int nChecks = 0;
  int nFails  = 0;

  scan_seq_ctrl #(.CHAIN_LEN(4), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .PAT_CNT(PAT_CNT),
    .PI_VALID(PI_VALID), .PI_DATA(PI_DATA), .PI_READY(PI_READY),
    .SO_VALID(SO_VALID), .SO_DATA(SO_DATA), .SO_READY(SO_READY),
    .SE(SE), .SI(SI), .SO(SO), .SCLK_EN(SCLK_EN), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // One row per clock cycle; exp is {SE, SI, SCLK_EN, PI_READY, SO_VALID, BUSY, DONE}.
  typedef struct {
    string      tag;
    logic       rst;
    logic       start;
    logic [7:0] pat;
    logic       pv;
    logic       pd;
    logic       sr;
    logic       so;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic addRow(input string tag, input logic st, input logic [7:0] pat,
                        input logic pv, input logic pd, input logic sr, input logic so,
                        input logic [6:0] e);
    vec_t v;
    v.tag = tag; v.rst = 1'b0; v.start = st; v.pat = pat;
    v.pv = pv; v.pd = pd; v.sr = sr; v.so = so; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    RST      = v.rst;
    START    = v.start;
    PAT_CNT  = v.pat;
    PI_VALID = v.pv;
    PI_DATA  = v.pd;
    SO_READY = v.sr;
    SO       = v.so;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int outVec();
    return int'({SE, SI, SCLK_EN, PI_READY, SO_VALID, SO_DATA, BUSY, DONE});
  endfunction

  int doneCyc;
  int overlap;
  int capMask;
  int doneCnt;
  int sclkSeen;
  int busySeen;

  initial begin
    RST = 1'b1; START = 1'b0; PAT_CNT = '0;
    PI_VALID = 1'b0; PI_DATA = 1'b0; SO_READY = 1'b0; SO = 1'b0;

    // Reset for two edges, with START raised alongside it; START must be dropped.
    @(negedge CLK); RST = 1'b1; START = 1'b1; PAT_CNT = 8'd1;
    @(negedge CLK); RST = 1'b1; START = 1'b1;
    @(negedge CLK); RST = 1'b0; START = 1'b0; #1;
    checkOutput("reset_idle", outVec(), 0);
    @(negedge CLK); #1;
    checkOutput("start_with_reset_ignored", outVec(), 0);

    // Session A: one pattern, stimulus 1,0,1,1, a second START while busy.
    addRow("A", 1, 1, 0, 0, 1, 0, 7'b0000000);
    addRow("A", 0, 0, 1, 1, 1, 1, 7'b1111010);
    addRow("A", 1, 5, 1, 0, 1, 0, 7'b1011010);
    addRow("A", 0, 0, 1, 1, 1, 1, 7'b1111010);
    addRow("A", 0, 0, 1, 1, 1, 0, 7'b1111010);
    addRow("A", 0, 0, 1, 1, 1, 1, 7'b0010010);
    addRow("A", 0, 0, 1, 1, 1, 1, 7'b1010110);
    addRow("A", 0, 0, 1, 1, 1, 0, 7'b1010110);
    addRow("A", 0, 0, 1, 1, 1, 1, 7'b1010110);
    addRow("A", 0, 0, 1, 1, 1, 0, 7'b1010110);
    addRow("A", 0, 0, 1, 1, 1, 1, 7'b0000011);
    addRow("A", 0, 0, 0, 0, 1, 0, 7'b0000000);
    // Session B: PI_VALID low for three cycles mid-load.
    addRow("B", 1, 1, 0, 0, 1, 0, 7'b0000000);
    addRow("B", 0, 0, 1, 1, 1, 1, 7'b1111010);
    addRow("B", 0, 0, 1, 0, 1, 0, 7'b1011010);
    addRow("B", 0, 0, 0, 1, 1, 1, 7'b1101010);
    addRow("B", 0, 0, 0, 0, 1, 0, 7'b1001010);
    addRow("B", 0, 0, 0, 1, 1, 1, 7'b1101010);
    addRow("B", 0, 0, 1, 1, 1, 0, 7'b1111010);
    addRow("B", 0, 0, 1, 0, 1, 1, 7'b1011010);
    addRow("B", 0, 0, 1, 1, 1, 1, 7'b0010010);
    addRow("B", 0, 0, 1, 1, 1, 0, 7'b1010110);
    addRow("B", 0, 0, 1, 1, 1, 1, 7'b1010110);
    addRow("B", 0, 0, 1, 1, 1, 0, 7'b1010110);
    addRow("B", 0, 0, 1, 1, 1, 1, 7'b1010110);
    addRow("B", 0, 0, 1, 1, 1, 0, 7'b0000011);
    addRow("B", 0, 0, 0, 0, 1, 0, 7'b0000000);
    // Session C: SO_READY low for three cycles during a pure unload.
    addRow("C", 1, 1, 0, 0, 1, 0, 7'b0000000);
    addRow("C", 0, 0, 1, 0, 1, 1, 7'b1011010);
    addRow("C", 0, 0, 1, 1, 1, 0, 7'b1111010);
    addRow("C", 0, 0, 1, 0, 1, 1, 7'b1011010);
    addRow("C", 0, 0, 1, 0, 1, 0, 7'b1011010);
    addRow("C", 0, 0, 1, 0, 1, 1, 7'b0010010);
    addRow("C", 0, 0, 1, 0, 1, 1, 7'b1010110);
    addRow("C", 0, 0, 1, 0, 0, 0, 7'b1000110);
    addRow("C", 0, 0, 1, 0, 0, 1, 7'b1000110);
    addRow("C", 0, 0, 1, 0, 0, 0, 7'b1000110);
    addRow("C", 0, 0, 0, 0, 1, 1, 7'b1010110);
    addRow("C", 0, 0, 0, 0, 1, 0, 7'b1010110);
    addRow("C", 0, 0, 0, 0, 1, 1, 7'b1010110);
    addRow("C", 0, 0, 0, 0, 1, 0, 7'b0000011);
    addRow("C", 0, 0, 0, 0, 1, 0, 7'b0000000);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [7:0] e;
      @(negedge CLK);
      applyStimulus(vecs[i]);
      #1;
      e = {vecs[i].exp[6:2], vecs[i].so & vecs[i].exp[6], vecs[i].exp[1:0]};
      checkOutput($sformatf("%s_row%0d", vecs[i].tag, i), outVec(), int'(e));
    end

    // Two patterns, never stalled: overlap of load and unload, captures, latency.
    @(negedge CLK); START = 1'b1; PAT_CNT = 8'd2;
    PI_VALID = 1'b1; PI_DATA = 1'b1; SO_READY = 1'b1; SO = 1'b0;
    @(negedge CLK); START = 1'b0;
    doneCyc = -1; overlap = 0; capMask = 0;
    for (int cyc = 1; cyc <= 40 && doneCyc < 0; cyc++) begin
      #1;
      if (PI_READY && SO_VALID) overlap++;
      if (SCLK_EN && !SE) capMask |= (1 << cyc);
      if (DONE) doneCyc = cyc;
      @(negedge CLK);
    end
    #1;
    checkOutput("n2_done_cycle", doneCyc, 15);
    checkOutput("n2_overlap_cycles", overlap, 4);
    checkOutput("n2_capture_cycles", capMask, (1 << 5) | (1 << 10));
    checkOutput("n2_idle_after", outVec(), 0);

    // Zero patterns: DONE on the first cycle, no chain clock, repeat START ignored.
    @(negedge CLK); START = 1'b1; PAT_CNT = 8'd0;
    doneCnt = 0; sclkSeen = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      START = (c == 1);
      #1;
      if (c == 1) checkOutput("zero_done_c1", int'({BUSY, DONE}), 3);
      doneCnt += int'(DONE);
      sclkSeen += int'(SCLK_EN);
    end
    START = 1'b0;
    checkOutput("zero_done_count", doneCnt, 1);
    checkOutput("zero_sclk_count", sclkSeen, 0);

    // Reset held two cycles mid-shift: idle at once, and no DONE afterwards.
    @(negedge CLK); START = 1'b1; PAT_CNT = 8'd1;
    PI_VALID = 1'b1; SO_READY = 1'b1;
    @(negedge CLK); START = 1'b0;
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); #1;
    checkOutput("rst_mid_first_edge", outVec(), 0);
    @(negedge CLK); RST = 1'b0; #1;
    checkOutput("rst_mid_released", outVec(), 0);
    doneCnt = 0; busySeen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK); #1;
      doneCnt += int'(DONE);
      busySeen += int'(BUSY);
    end
    checkOutput("rst_mid_no_done", doneCnt, 0);
    checkOutput("rst_mid_stays_idle", busySeen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
